// File: rtl/clause_evaluator.sv
// Scans a block of 3-literal clauses read from an external memory, classifying each as
// SAT / CONFLICT / UNIT / UNRESOLVED and summarising the whole block in registered outputs.
module clause_evaluator #(
    parameter int NUM_CLAUSES  = 16,
    parameter int VAR_ID_WIDTH = 8,
    parameter int VALUE_WIDTH  = 2,
    parameter int CLAUSE_WIDTH = 3 * (VAR_ID_WIDTH + VALUE_WIDTH + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [$clog2(NUM_CLAUSES):0]    num_clauses,
    output logic [$clog2(NUM_CLAUSES)-1:0]  read_addr,
    input  logic [CLAUSE_WIDTH-1:0]         read_data,
    output logic                            busy,
    output logic                            done,
    output logic [1:0]                      result,
    output logic [$clog2(NUM_CLAUSES):0]    sat_count,
    output logic [$clog2(NUM_CLAUSES)-1:0]  conflict_idx,
    output logic [$clog2(NUM_CLAUSES)-1:0]  unit_idx,
    output logic [VAR_ID_WIDTH-1:0]         unit_var,
    output logic [VALUE_WIDTH-1:0]          unit_val
);

    localparam int AW = $clog2(NUM_CLAUSES);
    localparam int CW = AW + 1;
    localparam int TW = VAR_ID_WIDTH + VALUE_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EVAL  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Literal value: {unknown, true}; an assigned literal that is not true is false.
    function automatic logic [1:0] lit_eval(input logic [VALUE_WIDTH-1:0] val, input logic neg);
        logic [1:0] r;
        if (val == VALUE_WIDTH'(0)) begin
            r = {1'b0, neg};
        end else if (val == VALUE_WIDTH'(1)) begin
            r = {1'b0, ~neg};
        end else begin
            r = 2'b10;
        end
        return r;
    endfunction

    state_t state_q, state_d;

    logic [TW-1:0]           term_s [3];
    logic [1:0]              lit_s  [3];
    logic [2:0]              true_s, unk_s, false_s;
    logic                    clause_sat_s, clause_conf_s, clause_unit_s;
    logic [VAR_ID_WIDTH-1:0] unit_var_s;
    logic                    unit_neg_s;
    logic [CW-1:0]           num_eff_s;

    logic [AW-1:0]           read_addr_q, read_addr_d;
    logic [CW-1:0]           num_q, num_d;
    logic [CW-1:0]           eval_idx_q, eval_idx_d;
    logic                    conf_seen_q, conf_seen_d;
    logic                    unit_seen_q, unit_seen_d;
    logic                    unres_seen_q, unres_seen_d;
    logic [CW-1:0]           sat_count_q, sat_count_d;
    logic [AW-1:0]           conflict_idx_q, conflict_idx_d;
    logic [AW-1:0]           unit_idx_q, unit_idx_d;
    logic [VAR_ID_WIDTH-1:0] unit_var_q, unit_var_d;
    logic [VALUE_WIDTH-1:0]  unit_val_q, unit_val_d;
    logic [1:0]              result_q, result_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    // Split the clause word into its three terms (term0 in the MSBs) and evaluate each literal.
    always_comb begin
        for (int t = 0; t < 3; t++) begin
            term_s[t] = read_data[CLAUSE_WIDTH-1-t*TW -: TW];
            lit_s[t]  = lit_eval(term_s[t][VALUE_WIDTH:1], term_s[t][0]);
        end
    end

    assign true_s  = {lit_s[2][0], lit_s[1][0], lit_s[0][0]};
    assign unk_s   = {lit_s[2][1], lit_s[1][1], lit_s[0][1]};
    assign false_s = ~(true_s | unk_s);

    assign clause_sat_s  = |true_s;
    assign clause_conf_s = (false_s == 3'b111);
    assign clause_unit_s = ~clause_sat_s &
                           ((unk_s == 3'b001) | (unk_s == 3'b010) | (unk_s == 3'b100));

    // Pick the single unknown term of a unit clause, wherever it sits.
    always_comb begin
        case (unk_s)
            3'b001: begin
                unit_var_s = term_s[0][TW-1 -: VAR_ID_WIDTH];
                unit_neg_s = term_s[0][0];
            end
            3'b010: begin
                unit_var_s = term_s[1][TW-1 -: VAR_ID_WIDTH];
                unit_neg_s = term_s[1][0];
            end
            3'b100: begin
                unit_var_s = term_s[2][TW-1 -: VAR_ID_WIDTH];
                unit_neg_s = term_s[2][0];
            end
            default: begin
                unit_var_s = '0;
                unit_neg_s = 1'b0;
            end
        endcase
    end

    assign num_eff_s = (num_clauses > CW'(NUM_CLAUSES)) ? CW'(NUM_CLAUSES) : num_clauses;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (num_eff_s == CW'(0)) ? S_DONE : S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: state_d = S_EVAL;
            S_EVAL: begin
                if (eval_idx_q == (num_q - CW'(1))) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_EVAL;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs, computed from the next state so the registered flags line up with it.
    always_comb begin
        busy_d = (state_d == S_FETCH) || (state_d == S_EVAL);
        done_d = (state_d == S_DONE);
    end

    // Address generation and per-clause accumulation.
    always_comb begin
        read_addr_d    = read_addr_q;
        num_d          = num_q;
        eval_idx_d     = eval_idx_q;
        conf_seen_d    = conf_seen_q;
        unit_seen_d    = unit_seen_q;
        unres_seen_d   = unres_seen_q;
        sat_count_d    = sat_count_q;
        conflict_idx_d = conflict_idx_q;
        unit_idx_d     = unit_idx_q;
        unit_var_d     = unit_var_q;
        unit_val_d     = unit_val_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    read_addr_d    = '0;
                    num_d          = num_eff_s;
                    eval_idx_d     = '0;
                    conf_seen_d    = 1'b0;
                    unit_seen_d    = 1'b0;
                    unres_seen_d   = 1'b0;
                    sat_count_d    = '0;
                    conflict_idx_d = '0;
                    unit_idx_d     = '0;
                    unit_var_d     = '0;
                    unit_val_d     = '0;
                end else begin
                    read_addr_d = read_addr_q;
                end
            end
            S_FETCH: begin
                read_addr_d = read_addr_q + AW'(1);
            end
            S_EVAL: begin
                read_addr_d = read_addr_q + AW'(1);
                eval_idx_d  = eval_idx_q + CW'(1);
                if (clause_sat_s) begin
                    sat_count_d = sat_count_q + CW'(1);
                end else if (clause_conf_s) begin
                    conf_seen_d = 1'b1;
                    conflict_idx_d = conf_seen_q ? conflict_idx_q : eval_idx_q[AW-1:0];
                end else if (clause_unit_s) begin
                    unit_seen_d = 1'b1;
                    if (!unit_seen_q) begin
                        unit_idx_d = eval_idx_q[AW-1:0];
                        unit_var_d = unit_var_s;
                        unit_val_d = {{(VALUE_WIDTH-1){1'b0}}, ~unit_neg_s};
                    end else begin
                        unit_idx_d = unit_idx_q;
                    end
                end else begin
                    unres_seen_d = 1'b1;
                end
            end
            S_DONE: begin
                read_addr_d = read_addr_q;
            end
            default: begin
                read_addr_d = '0;
            end
        endcase
    end

    // Summary code by priority: conflict, then unit, then unresolved, else all satisfied.
    always_comb begin
        if (conf_seen_d) begin
            result_d = 2'b01;
        end else if (unit_seen_d) begin
            result_d = 2'b10;
        end else if (unres_seen_d) begin
            result_d = 2'b11;
        end else begin
            result_d = 2'b00;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_addr_q    <= '0;
            num_q          <= '0;
            eval_idx_q     <= '0;
            conf_seen_q    <= 1'b0;
            unit_seen_q    <= 1'b0;
            unres_seen_q   <= 1'b0;
            sat_count_q    <= '0;
            conflict_idx_q <= '0;
            unit_idx_q     <= '0;
            unit_var_q     <= '0;
            unit_val_q     <= '0;
            result_q       <= 2'b00;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            read_addr_q    <= read_addr_d;
            num_q          <= num_d;
            eval_idx_q     <= eval_idx_d;
            conf_seen_q    <= conf_seen_d;
            unit_seen_q    <= unit_seen_d;
            unres_seen_q   <= unres_seen_d;
            sat_count_q    <= sat_count_d;
            conflict_idx_q <= conflict_idx_d;
            unit_idx_q     <= unit_idx_d;
            unit_var_q     <= unit_var_d;
            unit_val_q     <= unit_val_d;
            result_q       <= result_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign read_addr    = read_addr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result       = result_q;
    assign sat_count    = sat_count_q;
    assign conflict_idx = conflict_idx_q;
    assign unit_idx     = unit_idx_q;
    assign unit_var     = unit_var_q;
    assign unit_val     = unit_val_q;

endmodule

// File: tb/tb_clause_evaluator.sv
// Directed bench for clause_evaluator: a registered-read clause memory model, hand-built
// clause words and hand-computed timing and result expectations.
module tb_clause_evaluator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  num_clauses;
    logic [3:0]  read_addr;
    logic [32:0] read_data;
    logic        busy, done;
    logic [1:0]  result;
    logic [4:0]  sat_count;
    logic [3:0]  conflict_idx, unit_idx;
    logic [7:0]  unit_var;
    logic [1:0]  unit_val;

    logic [32:0] mem [16];

    int n_checks = 0;
    int n_errors = 0;

    clause_evaluator dut (
        .clk(clk), .rst(rst), .start(start), .num_clauses(num_clauses),
        .read_addr(read_addr), .read_data(read_data), .busy(busy), .done(done),
        .result(result), .sat_count(sat_count), .conflict_idx(conflict_idx),
        .unit_idx(unit_idx), .unit_var(unit_var), .unit_val(unit_val)
    );

    always #5 clk = ~clk;

    // One-cycle-latency clause memory.
    always @(posedge clk) read_data <= mem[read_addr];

    function automatic logic [10:0] lit(input logic [7:0] v, input logic [1:0] val, input logic n);
        return {v, val, n};
    endfunction

    function automatic logic [32:0] cl(input logic [10:0] a, input logic [10:0] b, input logic [10:0] c);
        return {a, b, c};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_res(input string tag, input logic [1:0] r, input int sc, input int ci,
                             input int ui, input int uv, input int uval);
        check_eq({tag, ".result"}, result, r);
        check_eq({tag, ".sat_count"}, sat_count, sc);
        check_eq({tag, ".conflict_idx"}, conflict_idx, ci);
        check_eq({tag, ".unit_idx"}, unit_idx, ui);
        check_eq({tag, ".unit_var"}, unit_var, uv);
        check_eq({tag, ".unit_val"}, unit_val, uval);
    endtask

    // Start a scan and measure clocks from the accepting edge to the edge that sees done.
    task automatic scan(input string tag, input int n, input int exp_lat, input bit pulse);
        int lat;
        int busy_n;
        lat = 0;
        busy_n = 0;
        @(negedge clk);
        start = 1'b1;
        num_clauses = 5'(n);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            busy_n += int'(busy);
            if (done) begin
                lat = c;
                break;
            end
            start = pulse;
        end
        start = 1'b0;
        check_eq({tag, ".latency"}, lat, exp_lat);
        check_eq({tag, ".busy_cycles"}, busy_n, exp_lat - 1);
        @(negedge clk);
        check_eq({tag, ".done_single"}, done, 1'b0);
    endtask

    logic [32:0] c_sat, c_unres, c_conf, c_unit5, c_unit9, c_unit7;
    int seen;

    initial begin
        c_sat   = cl(lit(8'd1, 2'b01, 1'b0), lit(8'd2, 2'b00, 1'b1), lit(8'd3, 2'b00, 1'b0));
        c_unres = cl(lit(8'd1, 2'b10, 1'b0), lit(8'd2, 2'b10, 1'b0), lit(8'd3, 2'b10, 1'b0));
        c_conf  = cl(lit(8'd4, 2'b00, 1'b0), lit(8'd5, 2'b00, 1'b0), lit(8'd6, 2'b00, 1'b0));
        c_unit5 = cl(lit(8'd10, 2'b00, 1'b0), lit(8'd11, 2'b01, 1'b1), lit(8'd5, 2'b10, 1'b0));
        c_unit9 = cl(lit(8'd9, 2'b11, 1'b1), lit(8'd2, 2'b00, 1'b0), lit(8'd3, 2'b00, 1'b0));
        c_unit7 = cl(lit(8'd7, 2'b11, 1'b0), lit(8'd2, 2'b00, 1'b0), lit(8'd8, 2'b01, 1'b1));
        for (int i = 0; i < 16; i++) mem[i] = c_unres;

        rst = 1'b1;
        start = 1'b0;
        num_clauses = 5'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("reset.busy", busy, 1'b0);
        check_eq("reset.done", done, 1'b0);
        check_eq("reset.read_addr", read_addr, 4'd0);
        check_res("reset", 2'b00, 0, 0, 0, 0, 0);

        // Power-on clause set: every literal unknown.
        scan("poweron", 4, 6, 1'b0);
        check_res("poweron", 2'b11, 0, 0, 0, 0, 0);

        mem[0] = c_sat;
        scan("sat1", 1, 3, 1'b0);
        check_res("sat1", 2'b00, 1, 0, 0, 0, 0);

        mem[1] = c_sat;
        mem[2] = c_conf;
        scan("conf", 3, 5, 1'b0);
        check_res("conf", 2'b01, 2, 2, 0, 0, 0);

        mem[1] = cl(lit(8'd1, 2'b01, 1'b1), lit(8'd2, 2'b00, 1'b0), lit(8'd3, 2'b10, 1'b1));
        scan("unit", 2, 4, 1'b0);
        check_res("unit", 2'b10, 1, 0, 1, 3, 0);

        mem[0] = c_unit7;
        scan("unit_t0", 1, 3, 1'b0);
        check_res("unit_t0", 2'b10, 0, 0, 0, 7, 1);

        // Mixed block: lowest-index capture of both conflict and unit, conflict wins priority.
        mem[0] = c_sat;  mem[1] = c_unit5; mem[2] = c_conf;
        mem[3] = c_unit9; mem[4] = c_conf; mem[5] = c_unres;
        scan("mixed", 6, 8, 1'b0);
        check_res("mixed", 2'b01, 1, 2, 1, 5, 1);
        repeat (3) @(negedge clk);
        check_res("hold", 2'b01, 1, 2, 1, 5, 1);

        scan("zero", 0, 1, 1'b0);
        check_res("zero", 2'b00, 0, 0, 0, 0, 0);

        for (int i = 0; i < 16; i++) mem[i] = c_sat;
        scan("clamp", 31, 18, 1'b0);
        check_res("clamp", 2'b00, 16, 0, 0, 0, 0);

        // Reset in the third busy cycle aborts the scan without a done pulse.
        mem[0] = c_conf;
        @(negedge clk);
        start = 1'b1;
        num_clauses = 5'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("abort.busy_before", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort.busy", busy, 1'b0);
        check_eq("abort.done", done, 1'b0);
        check_eq("abort.read_addr", read_addr, 4'd0);
        check_res("abort", 2'b00, 0, 0, 0, 0, 0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) seen++;
        end
        check_eq("abort.no_done", seen, 0);
        mem[0] = c_sat;
        scan("after_abort", 1, 3, 1'b0);
        check_res("after_abort", 2'b00, 1, 0, 0, 0, 0);

        // start held high throughout the scan changes nothing.
        mem[0] = c_sat; mem[1] = c_unit5; mem[2] = c_unres;
        scan("pulse", 3, 5, 1'b1);
        check_res("pulse", 2'b10, 1, 0, 1, 5, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
